// File: rtl/bp_fpga_host_axil_pkg.sv
// bp_fpga_host_axil_pkg: shared types and constants for the host AXI-Lite master.
// Contents: the sequencer state enum, the AXI response codes and the default protection value.
package bp_fpga_host_axil_pkg;

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/bp_fpga_host_axil_if.sv
// bp_fpga_host_axil_if: bundles the command/response handshake and the AXI-Lite master bus.
// Ports and modports:
//   master - the sequencer's view: it takes commands and drives the aw/w/ar channels.
//   slave  - the far side: it drives commands and the AXI-Lite slave responses.
interface bp_fpga_host_axil_if #(
    parameter int AXIL_ADDR_WIDTH = 64,
    parameter int AXIL_DATA_WIDTH = 32
);
    logic                         cmd_v_i;
    logic                         cmd_ready_o;
    logic                         cmd_we_i;
    logic [AXIL_ADDR_WIDTH-1:0]   cmd_addr_i;
    logic [AXIL_DATA_WIDTH-1:0]   cmd_wdata_i;
    logic                         resp_v_o;
    logic                         resp_ready_i;
    logic [AXIL_DATA_WIDTH-1:0]   resp_rdata_o;
    logic                         resp_err_o;
    logic                         timeout_o;
    logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr;
    logic                         m_axil_awvalid;
    logic                         m_axil_awready;
    logic [2:0]                   m_axil_awprot;
    logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata;
    logic                         m_axil_wvalid;
    logic                         m_axil_wready;
    logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb;
    logic                         m_axil_bvalid;
    logic                         m_axil_bready;
    logic [1:0]                   m_axil_bresp;
    logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr;
    logic                         m_axil_arvalid;
    logic                         m_axil_arready;
    logic [2:0]                   m_axil_arprot;
    logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata;
    logic                         m_axil_rvalid;
    logic                         m_axil_rready;
    logic [1:0]                   m_axil_rresp;

    modport master (
        input  cmd_v_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, resp_ready_i,
               m_axil_awready, m_axil_wready, m_axil_bvalid, m_axil_bresp,
               m_axil_arready, m_axil_rdata, m_axil_rvalid, m_axil_rresp,
        output cmd_ready_o, resp_v_o, resp_rdata_o, resp_err_o, timeout_o,
               m_axil_awaddr, m_axil_awvalid, m_axil_awprot, m_axil_wdata, m_axil_wvalid,
               m_axil_wstrb, m_axil_bready, m_axil_araddr, m_axil_arvalid, m_axil_arprot,
               m_axil_rready
    );

    modport slave (
        output cmd_v_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, resp_ready_i,
               m_axil_awready, m_axil_wready, m_axil_bvalid, m_axil_bresp,
               m_axil_arready, m_axil_rdata, m_axil_rvalid, m_axil_rresp,
        input  cmd_ready_o, resp_v_o, resp_rdata_o, resp_err_o, timeout_o,
               m_axil_awaddr, m_axil_awvalid, m_axil_awprot, m_axil_wdata, m_axil_wvalid,
               m_axil_wstrb, m_axil_bready, m_axil_araddr, m_axil_arvalid, m_axil_arprot,
               m_axil_rready
    );

endinterface

// File: rtl/bp_fpga_host_axil_master.sv
// bp_fpga_host_axil_master: single-outstanding AXI-Lite master sequencing host MMIO commands.
// Ports:
//   m_axil_aclk    - clock
//   m_axil_aresetn - asynchronous active-low reset
//   bus            - master modport: cmd/resp handshake, sticky watchdog flag, AXI-Lite aw/w/b/ar/r
module bp_fpga_host_axil_master
    import bp_fpga_host_axil_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 64,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input logic             m_axil_aclk,
    input logic             m_axil_aresetn,
    bp_fpga_host_axil_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_e                     state, state_n;
    logic [AXIL_ADDR_WIDTH-1:0] addr;
    logic [AXIL_DATA_WIDTH-1:0] wdata, rdata;
    logic                       err, aw_done, w_done, timeout, accept, waiting;
    logic [CNT_W-1:0]           wdog;

    assign accept  = bus.cmd_v_i & bus.cmd_ready_o;
    assign waiting = state inside {WRITE, WRESP, READ, RDATA};

    assign bus.cmd_ready_o    = (state == IDLE) & m_axil_aresetn;
    assign bus.resp_v_o       = state == RESP;
    assign bus.resp_rdata_o   = rdata;
    assign bus.resp_err_o     = err;
    assign bus.timeout_o      = timeout;
    // Valids decode straight from registered state, so reset drops them at once.
    assign bus.m_axil_awaddr  = addr;
    assign bus.m_axil_awvalid = (state == WRITE) & ~aw_done;
    assign bus.m_axil_awprot  = PROT_DEFAULT;
    assign bus.m_axil_wdata   = wdata;
    assign bus.m_axil_wvalid  = (state == WRITE) & ~w_done;
    assign bus.m_axil_wstrb   = '1;
    assign bus.m_axil_bready  = state == WRESP;
    assign bus.m_axil_araddr  = addr;
    assign bus.m_axil_arvalid = state == READ;
    assign bus.m_axil_arprot  = PROT_DEFAULT;
    assign bus.m_axil_rready  = state == RDATA;

    always_ff @(posedge m_axil_aclk or negedge m_axil_aresetn) begin
        if (!m_axil_aresetn) state <= IDLE;
        else                 state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.cmd_v_i) state_n = bus.cmd_we_i ? WRITE : READ;
            WRITE:   if ((aw_done | bus.m_axil_awready) & (w_done | bus.m_axil_wready)) state_n = WRESP;
            WRESP:   if (bus.m_axil_bvalid) state_n = RESP;
            READ:    if (bus.m_axil_arready) state_n = RDATA;
            RDATA:   if (bus.m_axil_rvalid) state_n = RESP;
            RESP:    if (bus.resp_ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge m_axil_aclk or negedge m_axil_aresetn) begin
        if (!m_axil_aresetn) begin
            addr    <= '0;
            wdata   <= '0;
            rdata   <= '0;
            err     <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wdog    <= '0;
            timeout <= 1'b0;
        end else begin
            if (accept) begin
                addr    <= bus.cmd_addr_i;
                wdata   <= bus.cmd_wdata_i;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                wdog    <= '0;
            end
            // Valid is only high while not done, so ready alone marks the handshake.
            if (state == WRITE) begin
                aw_done <= aw_done | bus.m_axil_awready;
                w_done  <= w_done | bus.m_axil_wready;
            end
            if (state == WRESP && bus.m_axil_bvalid) begin
                rdata <= '0;
                err   <= bus.m_axil_bresp != OKAY;
            end
            if (state == RDATA && bus.m_axil_rvalid) begin
                rdata <= bus.m_axil_rdata;
                err   <= bus.m_axil_rresp != OKAY;
            end
            if (waiting && wdog != CNT_MAX) wdog <= wdog + 1'b1;
            // Flag in the same edge the count reaches the limit; never cleared until reset.
            if (waiting && wdog == CNT_MAX - 1'b1) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_fpga_host_axil_master.sv
// tb_bp_fpga_host_axil_master: scoreboard bench with a memory-backed AXI-Lite slave model.
// Ports: none. The slave returns a response code taken from address bits [9:8] and only
// stores writes whose code is OKAY/EXOKAY; expectations come from a reference memory.
module tb_bp_fpga_host_axil_master;
    import bp_fpga_host_axil_pkg::*;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_fpga_host_axil_if #(.AXIL_ADDR_WIDTH(AW), .AXIL_DATA_WIDTH(DW)) bus ();

    bp_fpga_host_axil_master #(
        .AXIL_ADDR_WIDTH(AW),
        .AXIL_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .m_axil_aclk(clk),
        .m_axil_aresetn(rst_n),
        .bus(bus)
    );

    int n_vec = 0;
    int n_fail = 0;
    exp_t sb[$];
    logic [DW-1:0] ref_mem [bit [AW-1:0]];
    logic [DW-1:0] slv_mem [bit [AW-1:0]];

    int k_aw = 0, k_w = 0, k_ar = 0, k_b = 0, k_r = 0, k_hold = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [1:0] resp_of(bit [AW-1:0] a);
        return a[9:8];
    endfunction

    function automatic logic [DW-1:0] mem_default(bit [AW-1:0] a);
        return a[31:0] ^ 32'hA5A5_5A5A;
    endfunction

    task automatic set_knobs(input int aw, input int w, input int ar, input int b, input int r, input int h);
        k_aw = aw; k_w = w; k_ar = ar; k_b = b; k_r = r; k_hold = h;
    endtask

    // Returns at the negedge after acceptance (first cycle the DUT is busy).
    task automatic issue(input bit we, input bit [AW-1:0] a, input bit [DW-1:0] d);
        exp_t e;
        logic [1:0] rc;
        int t;
        @(negedge clk);
        bus.cmd_v_i = 1'b1;
        bus.cmd_we_i = we;
        bus.cmd_addr_i = a;
        bus.cmd_wdata_i = d;
        t = 0;
        while (!bus.cmd_ready_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            check("cmd_accept_timeout", 0, 1);
            bus.cmd_v_i = 1'b0;
            return;
        end
        aw_wait = k_aw; w_wait = k_w; ar_wait = k_ar; b_wait = k_b; r_wait = k_r;
        rc = resp_of(a);
        e.err = rc != OKAY;
        if (we) begin
            e.rdata = '0;
            if (!rc[1]) ref_mem[a] = d;
        end else begin
            e.rdata = ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
        end
        sb.push_back(e);
        @(negedge clk);
        bus.cmd_v_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || !bus.cmd_ready_o) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("idle_timeout", 0, 1);
    endtask

    // AXI-Lite slave: all decisions at negedge take effect at the following posedge.
    initial begin
        int aw_hs, w_hs, ar_hs;
        bit b_fired, r_fired, aw_stall, w_stall, ar_stall;
        logic [AW-1:0] s_awaddr, s_araddr, last_aw, last_ar;
        logic [DW-1:0] s_wdata, last_w;
        aw_hs = 0; w_hs = 0; ar_hs = 0;
        b_fired = 0; r_fired = 0; aw_stall = 0; w_stall = 0; ar_stall = 0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; last_aw = '0; last_ar = '0; last_w = '0;
        bus.m_axil_awready = 0; bus.m_axil_wready = 0; bus.m_axil_arready = 0;
        bus.m_axil_bvalid = 0; bus.m_axil_bresp = 0;
        bus.m_axil_rvalid = 0; bus.m_axil_rresp = 0; bus.m_axil_rdata = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.m_axil_awready = 0; bus.m_axil_wready = 0; bus.m_axil_arready = 0;
                bus.m_axil_bvalid = 0; bus.m_axil_rvalid = 0;
                aw_hs = 0; w_hs = 0; ar_hs = 0;
                b_fired = 0; r_fired = 0; aw_stall = 0; w_stall = 0; ar_stall = 0;
                continue;
            end
            if (b_fired) begin bus.m_axil_bvalid = 0; b_fired = 0; end
            if (r_fired) begin bus.m_axil_rvalid = 0; r_fired = 0; end
            if (bus.m_axil_bready) check("bready_after_aw_and_w", 64'(aw_hs > 0 && w_hs > 0), 1);
            if (bus.m_axil_rready) check("rready_after_ar", 64'(ar_hs > 0), 1);
            if (aw_stall) begin
                check("awvalid_held", bus.m_axil_awvalid, 1);
                check("awaddr_stable", bus.m_axil_awaddr, last_aw);
            end
            if (w_stall) begin
                check("wvalid_held", bus.m_axil_wvalid, 1);
                check("wdata_stable", bus.m_axil_wdata, last_w);
            end
            if (ar_stall) begin
                check("arvalid_held", bus.m_axil_arvalid, 1);
                check("araddr_stable", bus.m_axil_araddr, last_ar);
            end
            if (!bus.m_axil_bvalid && aw_hs > 0 && w_hs > 0) begin
                if (b_wait == 0) begin
                    bus.m_axil_bvalid = 1;
                    bus.m_axil_bresp = resp_of(s_awaddr);
                end else b_wait--;
            end
            if (!bus.m_axil_rvalid && ar_hs > 0) begin
                if (r_wait == 0) begin
                    bus.m_axil_rvalid = 1;
                    bus.m_axil_rresp = resp_of(s_araddr);
                    bus.m_axil_rdata = slv_mem.exists(s_araddr) ? slv_mem[s_araddr] : mem_default(s_araddr);
                end else r_wait--;
            end
            bus.m_axil_awready = aw_wait == 0;
            bus.m_axil_wready = w_wait == 0;
            bus.m_axil_arready = ar_wait == 0;
            if (bus.m_axil_awvalid) begin
                if (bus.m_axil_awready) begin aw_hs++; s_awaddr = bus.m_axil_awaddr; end
                else aw_wait--;
            end
            if (bus.m_axil_wvalid) begin
                if (bus.m_axil_wready) begin w_hs++; s_wdata = bus.m_axil_wdata; end
                else w_wait--;
            end
            if (bus.m_axil_arvalid) begin
                if (bus.m_axil_arready) begin ar_hs++; s_araddr = bus.m_axil_araddr; end
                else ar_wait--;
            end
            aw_stall = bus.m_axil_awvalid && !bus.m_axil_awready;
            w_stall = bus.m_axil_wvalid && !bus.m_axil_wready;
            ar_stall = bus.m_axil_arvalid && !bus.m_axil_arready;
            last_aw = bus.m_axil_awaddr;
            last_w = bus.m_axil_wdata;
            last_ar = bus.m_axil_araddr;
            if (bus.m_axil_bvalid && bus.m_axil_bready) begin
                if (!bus.m_axil_bresp[1]) slv_mem[s_awaddr] = s_wdata;
                check("aw_handshakes", 64'(aw_hs), 1);
                check("w_handshakes", 64'(w_hs), 1);
                aw_hs = 0; w_hs = 0; b_fired = 1;
            end
            if (bus.m_axil_rvalid && bus.m_axil_rready) begin
                check("ar_handshakes", 64'(ar_hs), 1);
                ar_hs = 0; r_fired = 1;
            end
        end
    end

    // Response monitor: consumes responses and compares against the scoreboard.
    initial begin
        int hold;
        bit stall;
        logic [DW-1:0] last_rd;
        logic last_err;
        exp_t e;
        hold = 0; stall = 0; last_rd = '0; last_err = 0;
        bus.resp_ready_i = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.resp_ready_i = 0;
                stall = 0;
                continue;
            end
            if (stall) begin
                check("resp_v_held", bus.resp_v_o, 1);
                check("resp_rdata_stable", bus.resp_rdata_o, last_rd);
                check("resp_err_stable", bus.resp_err_o, last_err);
            end
            if (bus.resp_v_o) begin
                check("no_accept_during_resp", bus.cmd_ready_o, 0);
                if (!stall) hold = k_hold;
                bus.resp_ready_i = hold == 0;
                if (hold > 0) hold--;
                if (bus.resp_ready_i) begin
                    stall = 0;
                    if (sb.size() == 0) check("resp_expected", 0, 1);
                    else begin
                        e = sb.pop_front();
                        check("resp_rdata", bus.resp_rdata_o, e.rdata);
                        check("resp_err", bus.resp_err_o, e.err);
                    end
                end else begin
                    stall = 1;
                    last_rd = bus.resp_rdata_o;
                    last_err = bus.resp_err_o;
                end
            end else begin
                bus.resp_ready_i = 0;
                stall = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        bus.cmd_v_i = 0; bus.cmd_we_i = 0; bus.cmd_addr_i = '0; bus.cmd_wdata_i = '0;
        slv_mem[64'h20] = 32'h1234_5678;
        ref_mem[64'h20] = 32'h1234_5678;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready_o, 0);
        check("rst_valids", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_arvalid,
                             bus.m_axil_bready, bus.m_axil_rready, bus.resp_v_o}, 0);
        check("rst_resp_rdata", bus.resp_rdata_o, 0);
        check("rst_resp_err", bus.resp_err_o, 0);
        check("rst_timeout", bus.timeout_o, 0);
        check("rst_awaddr", bus.m_axil_awaddr, 0);
        rst_n = 1;
        @(negedge clk);
        check("cmd_ready_after_reset", bus.cmd_ready_o, 1);

        // Minimum-latency write against an always-ready slave.
        set_knobs(0, 0, 0, 0, 0, 0);
        issue(1, 64'h10, 32'hDEAD_BEEF);
        check("w1_awvalid", bus.m_axil_awvalid, 1);
        check("w1_wvalid", bus.m_axil_wvalid, 1);
        check("w1_awaddr", bus.m_axil_awaddr, 64'h10);
        check("w1_wdata", bus.m_axil_wdata, 32'hDEAD_BEEF);
        check("w1_wstrb", bus.m_axil_wstrb, 4'hF);
        check("w1_prot", {bus.m_axil_awprot, bus.m_axil_arprot}, 0);
        @(negedge clk);
        check("w1_bready_cycle2", bus.m_axil_bready, 1);
        @(negedge clk);
        check("w1_resp_v_cycle3", bus.resp_v_o, 1);
        wait_idle();

        // Read with arready stalled five cycles.
        set_knobs(0, 0, 5, 0, 0, 0);
        issue(0, 64'h20, 32'h0);
        for (int i = 0; i < 6; i++) begin
            check("r1_arvalid_held", bus.m_axil_arvalid, 1);
            check("r1_araddr", bus.m_axil_araddr, 64'h20);
            @(negedge clk);
        end
        check("r1_arvalid_dropped", bus.m_axil_arvalid, 0);
        wait_idle();

        // aw before w, w before aw, both together; then read each back.
        set_knobs(0, 1, 0, 0, 0, 0);
        issue(1, 64'h40, 32'h0000_0040);
        wait_idle();
        set_knobs(1, 0, 0, 0, 0, 0);
        issue(1, 64'h50, 32'h0000_0050);
        wait_idle();
        set_knobs(0, 0, 0, 1, 0, 0);
        issue(1, 64'h60, 32'h0000_0060);
        wait_idle();
        set_knobs(0, 0, 1, 0, 2, 1);
        issue(0, 64'h40, 0);
        issue(0, 64'h50, 0);
        issue(0, 64'h60, 0);
        wait_idle();

        // Error responses held for four cycles; next command queued meanwhile.
        set_knobs(0, 0, 0, 0, 0, 4);
        issue(0, 64'h200, 0);
        issue(1, 64'h300, 32'hCAFE_F00D);
        wait_idle();
        check("timeout_clear_before_stall", bus.timeout_o, 0);

        // Watchdog: bvalid withheld well past the limit.
        set_knobs(0, 0, 0, 12, 0, 0);
        issue(1, 64'h70, 32'h7777_0070);
        repeat (7) @(negedge clk);
        check("timeout_at_8_cycles_low", bus.timeout_o, 0);
        @(negedge clk);
        check("timeout_after_8_cycles", bus.timeout_o, 1);
        wait_idle();
        check("timeout_sticky", bus.timeout_o, 1);

        // Reset while waiting in WRESP.
        set_knobs(0, 0, 0, 6, 0, 0);
        issue(1, 64'h300, 32'h1111_2222);
        for (int t = 0; t < 50 && !bus.m_axil_bready; t++) @(negedge clk);
        check("reached_wresp", bus.m_axil_bready, 1);
        rst_n = 0;
        #1;
        check("reset_drops_valids", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_arvalid,
                                     bus.m_axil_bready, bus.m_axil_rready, bus.resp_v_o}, 0);
        check("reset_clears_timeout", bus.timeout_o, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("cmd_ready_after_midreset", bus.cmd_ready_o, 1);
        set_knobs(1, 0, 1, 0, 1, 0);
        issue(0, 64'h40, 0);
        wait_idle();

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            bit we;
            bit [AW-1:0] a;
            we = 1'($urandom_range(0, 1));
            a = 64'($urandom_range(0, 63)) << 4;
            if ($urandom_range(0, 3) == 0) a = a | 64'hF000_0000_0000_0000;
            set_knobs($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            issue(we, a, $urandom);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_fpga_host_axil_master.md
Name: bp_fpga_host_axil_master

Overview:
- Single-outstanding AXI4-Lite master that sequences driver commands onto the FPGA host's s_axil control port.
- It is the test driver / host-control sequencer between a simple valid/ready command interface and the host MMIO/NBF register space.
- It accepts one read or write command, runs the AXI-Lite channel handshakes, and returns one response carrying data and an error flag.
- A watchdog flags slaves that do not respond.

Parameters:
AXIL_ADDR_WIDTH, 64, AXI-Lite address width (matches host S_AXIL_ADDR_WIDTH)
AXIL_DATA_WIDTH, 32, AXI-Lite data width (matches host S_AXIL_DATA_WIDTH)
TIMEOUT_CYCLES, 1024, cycles in a bus-wait state before timeout_o sets; must be >= 1

Ports:
m_axil_aclk  in  1  clock
m_axil_aresetn  in  1  reset, asynchronous, active-low
cmd_v_i  in  1  command valid
cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o
cmd_we_i  in  1  1 = write, 0 = read
cmd_addr_i  in  AXIL_ADDR_WIDTH  target address
cmd_wdata_i  in  AXIL_DATA_WIDTH  write data
resp_v_o  out  1  response valid
resp_ready_i  in  1  response consumed when resp_v_o & resp_ready_i
resp_rdata_o  out  AXIL_DATA_WIDTH  read data; 0 for writes
resp_err_o  out  1  captured bresp/rresp != OKAY
timeout_o  out  1  sticky watchdog flag
m_axil_awaddr  out  AXIL_ADDR_WIDTH  write address
m_axil_awvalid  out  1  write address valid
m_axil_awready  in  1  write address ready
m_axil_awprot  out  3  tied 3'b000
m_axil_wdata  out  AXIL_DATA_WIDTH  write data
m_axil_wvalid  out  1  write data valid
m_axil_wready  in  1  write data ready
m_axil_wstrb  out  AXIL_DATA_WIDTH/8  tied all-ones
m_axil_bvalid  in  1  write response valid
m_axil_bready  out  1  write response ready
m_axil_bresp  in  2  write response code
m_axil_araddr  out  AXIL_ADDR_WIDTH  read address
m_axil_arvalid  out  1  read address valid
m_axil_arready  in  1  read address ready
m_axil_arprot  out  3  tied 3'b000
m_axil_rdata  in  AXIL_DATA_WIDTH  read data
m_axil_rvalid  in  1  read data valid
m_axil_rready  out  1  read data ready
m_axil_rresp  in  2  read response code

Behaviour:
- Reset (m_axil_aresetn=0, asynchronous): state IDLE; awvalid, wvalid, arvalid, bready, rready, resp_v_o, timeout_o = 0; resp_rdata_o = 0; resp_err_o = 0; address/data registers = 0. Asserting reset mid-transaction drops all valids immediately; the in-flight command is lost.
- States: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- cmd_ready_o = (state == IDLE) and not in reset. On accept, latch addr, wdata and we, and clear the watchdog counter.
  - we=1: go to WRITE.
  - we=0: go to READ.
- WRITE: awvalid and wvalid are registered and rise the cycle after accept. Each deasserts independently on its own handshake; aw_done and w_done flags track completion. Either order, or both in the same cycle, is legal. When both are done, go to WRESP.
- WRESP: bready=1. On bvalid, capture err = (bresp != 2'b00), set rdata = 0, go to RESP.
- READ: arvalid=1 until arready, then go to RDATA.
- RDATA: rready=1. On rvalid, capture rdata and err = (rresp != 2'b00), go to RESP.
- RESP: resp_v_o=1. resp_rdata_o and resp_err_o are held stable until resp_ready_i, then return to IDLE. No new command is accepted in the same cycle as the response is consumed.
- AXI rule: addr/data outputs are stable while the corresponding valid is high and ready is low. Valids never drop without a handshake, except on reset.
- Minimum latency with an always-ready slave responding in the same cycle:
  - Write: accept at cycle 0, aw/w handshake at cycle 1, b handshake at cycle 2, resp_v_o at cycle 3.
  - Read: accept at cycle 0, ar handshake at cycle 1, r handshake at cycle 2, resp_v_o at cycle 3.
- Watchdog: counter of width $clog2(TIMEOUT_CYCLES+1).
  - Increments each cycle in WRITE, WRESP, READ or RDATA; saturates at TIMEOUT_CYCLES.
  - timeout_o sets when the count reaches TIMEOUT_CYCLES and stays set until reset.
  - The transaction is not abandoned; the FSM keeps waiting.
- Unexpected bvalid/rvalid outside WRESP/RDATA is ignored, since bready/rready are 0.

Decomposition:
- Package bp_fpga_host_axil_pkg holds:
  - the state enum;
  - AXI response constants: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the default prot value 3'b000.
- No sub-module is needed; the watchdog counter and FSM live inline.

Test Plan:
- Write addr 0x0000_0010, data 0xDEAD_BEEF, slave always ready, bresp=OKAY -> awaddr/wdata driven on cycle 1; resp_v_o on cycle 3 with err=0, rdata=0.
- Read addr 0x0000_0020, slave returns rdata 0x1234_5678 after 5 stall cycles on arready -> arvalid held 6 cycles with a stable address; resp_rdata_o = 0x1234_5678, err=0.
- Write with awready one cycle before wready, then the reverse order, then both together -> exactly one aw and one w handshake each time; bready rises only after both complete.
- Read with rresp=SLVERR, then write with bresp=DECERR -> resp_err_o=1 for both; resp held 4 cycles while resp_ready_i=0, with no new cmd accepted.
- TIMEOUT_CYCLES=8, slave never asserts bvalid -> timeout_o=1 after 8 cycles in the wait states; a late bvalid still yields a response; timeout_o stays 1.
- Reset asserted during WRESP -> all valids and bready drop within the same cycle; after release cmd_ready_o=1 and a new read completes normally.
